dmem_arbiter: RTL and testbench

- Shares the single-port dmem (12-bit address, 32-bit data, clocked on ~clock) between the processor and an I/O master, such as game logic that reads and writes the mole/score words.
- Sits between processor/skeleton and dmem.
- Processor has default priority. The I/O master uses a latched req/ack handshake.
- A starvation counter forces an I/O grant and stalls the processor when needed.

---
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between the processor (default owner) and an I/O master
// with a latched req/ack handshake; a wait counter forces an I/O grant against a busy processor.
module dmem_arbiter #(
   parameter int MAX_WAIT = 8,
   parameter int CNT_W    = 4,
   parameter int STAT_W   = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              proc_en,
   input  logic              proc_wren,
   input  logic [11:0]       proc_addr,
   input  logic [31:0]       proc_wdata,
   output logic [31:0]       proc_q,
   output logic              proc_stall,
   input  logic              io_req,
   input  logic              io_wren,
   input  logic [11:0]       io_addr,
   input  logic [31:0]       io_wdata,
   output logic              io_busy,
   output logic              io_ack,
   output logic [31:0]       io_rdata,
   output logic [11:0]       mem_addr,
   output logic [31:0]       mem_data,
   output logic              mem_wren,
   input  logic [31:0]       mem_q,
   output logic [STAT_W-1:0] stall_count
);

   typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;

   localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic [11:0]         lat_addr_q, lat_addr_d;
   logic [31:0]         lat_wdata_q, lat_wdata_d;
   logic                lat_wren_q, lat_wren_d;
   logic [31:0]         io_rdata_q, io_rdata_d;
   logic [STAT_W-1:0]   stall_count_q, stall_count_d;
   logic                grant_io;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      lat_addr_d    = lat_addr_q;
      lat_wdata_d   = lat_wdata_q;
      lat_wren_d    = lat_wren_q;
      io_rdata_d    = io_rdata_q;
      stall_count_d = stall_count_q;
      grant_io      = 1'b0;
      mem_addr      = proc_addr;
      mem_data      = proc_wdata;
      mem_wren      = proc_en & proc_wren;
      proc_stall    = 1'b0;

      unique case (state_q)
         IDLE, ACK: begin
            state_d = IDLE;
            if (io_req) begin
               state_d     = PEND;
               lat_addr_d  = io_addr;
               lat_wdata_d = io_wdata;
               lat_wren_d  = io_wren;
               wait_cnt_d  = '0;
            end
         end
         PEND: begin
            grant_io = !proc_en || (wait_cnt_q >= MAX_WAIT_C);
            if (grant_io) begin
               mem_addr   = lat_addr_q;
               mem_data   = lat_wdata_q;
               mem_wren   = lat_wren_q;
               proc_stall = proc_en;
               state_d    = ACK;
               wait_cnt_d = '0;
               // dmem is clocked on the falling edge, so q already holds the granted read
               if (!lat_wren_q) io_rdata_d = mem_q;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (proc_stall && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         wait_cnt_q    <= '0;
         lat_addr_q    <= '0;
         lat_wdata_q   <= '0;
         lat_wren_q    <= 1'b0;
         io_rdata_q    <= '0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         lat_addr_q    <= lat_addr_d;
         lat_wdata_q   <= lat_wdata_d;
         lat_wren_q    <= lat_wren_d;
         io_rdata_q    <= io_rdata_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign io_busy     = (state_q == PEND);
   assign io_ack      = (state_q == ACK);
   assign io_rdata    = io_rdata_q;
   assign proc_q      = mem_q;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter: a transaction-level model of the
// arbitration rules plus a falling-edge dmem model, compared against the DUT every cycle.
module tb_dmem_arbiter;

   localparam int MAX_WAIT = 8;
   localparam int STAT_W   = 4;
   localparam int SAT      = (1 << STAT_W) - 1;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              proc_en = 1'b0, proc_wren = 1'b0;
   logic [11:0]       proc_addr = '0;
   logic [31:0]       proc_wdata = '0;
   logic [31:0]       proc_q;
   logic              proc_stall;
   logic              io_req = 1'b0, io_wren = 1'b0;
   logic [11:0]       io_addr = '0;
   logic [31:0]       io_wdata = '0;
   logic              io_busy, io_ack;
   logic [31:0]       io_rdata;
   logic [11:0]       mem_addr;
   logic [31:0]       mem_data;
   logic              mem_wren;
   logic [31:0]       mem_q = '0;
   logic [STAT_W-1:0] stall_count;

   int n_checks = 0;
   int n_pass   = 0;

   dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4), .STAT_W(STAT_W)) dut (
      .clock(clock), .reset(reset),
      .proc_en(proc_en), .proc_wren(proc_wren), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
      .proc_q(proc_q), .proc_stall(proc_stall),
      .io_req(io_req), .io_wren(io_wren), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_busy(io_busy), .io_ack(io_ack), .io_rdata(io_rdata),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
      .stall_count(stall_count)
   );

   always #5 clock = ~clock;

   // dmem: single port, clocked on the falling edge, new data on read-during-write
   logic [31:0] mem [4096];
   always @(negedge clock) begin
      if (mem_wren) mem[mem_addr] = mem_data;
      mem_q = mem[mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Transaction-level model: one outstanding request, counted losses, a one-cycle ack.
   typedef struct packed {
      logic        wren;
      logic [11:0] addr;
      logic [31:0] wdata;
   } io_txn_t;

   io_txn_t     m_req     = '0;
   bit          m_pending = 1'b0;
   bit          m_ack     = 1'b0;
   int          m_losses  = 0;
   logic [31:0] m_rdata   = '0;
   int          m_stalls  = 0;

   function automatic bit m_io_owns();
      return m_pending && (!proc_en || (m_losses >= MAX_WAIT));
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_req = '0; m_pending = 1'b0; m_ack = 1'b0; m_losses = 0; m_rdata = '0; m_stalls = 0;
      end else if (m_io_owns()) begin
         if (proc_en && m_stalls < SAT) m_stalls++;
         if (!m_req.wren) m_rdata = mem[m_req.addr];
         m_pending = 1'b0;
         m_ack     = 1'b1;
      end else if (m_pending) begin
         m_losses++;
         m_ack = 1'b0;
      end else begin
         m_ack = 1'b0;
         if (io_req) begin
            m_pending = 1'b1;
            m_losses  = 0;
            m_req     = '{wren: io_wren, addr: io_addr, wdata: io_wdata};
         end
      end
   end

   // Compare process: late in each cycle, after inputs and the falling-edge read have settled.
   always @(posedge clock) begin
      bit owns;
      #7;
      owns = m_io_owns();
      check("io_busy",     32'(io_busy),     32'(m_pending));
      check("io_ack",      32'(io_ack),      32'(m_ack));
      check("io_rdata",    io_rdata,         m_rdata);
      check("stall_count", 32'(stall_count), 32'(m_stalls));
      check("proc_stall",  32'(proc_stall),  32'(owns && proc_en));
      check("mem_addr",    32'(mem_addr),    32'(owns ? m_req.addr : proc_addr));
      check("mem_data",    mem_data,         owns ? m_req.wdata : proc_wdata);
      check("mem_wren",    32'(mem_wren),    32'(owns ? m_req.wren : (proc_en & proc_wren)));
      check("proc_q",      proc_q,           mem_q);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int owned, acks;
      bit found;

      for (int i = 0; i < 4096; i++) mem[i] = $urandom();

      // reset state
      tick();
      check("rst_busy",  32'(io_busy),     32'd0);
      check("rst_ack",   32'(io_ack),      32'd0);
      check("rst_rdata", io_rdata,         32'd0);
      check("rst_stall", 32'(stall_count), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // uncontended read
      mem[12'h010] = 32'hDEAD_BEEF;
      proc_en = 1'b0; io_req = 1'b1; io_wren = 1'b0; io_addr = 12'h010;
      tick();
      io_req = 1'b0;
      #1;
      check("rd_busy",    32'(io_busy),  32'd1);
      check("rd_addr",    32'(mem_addr), 32'h010);
      tick();
      check("rd_ack",     32'(io_ack),   32'd1);
      check("rd_data",    io_rdata,      32'hDEAD_BEEF);
      tick();
      check("rd_ack_end", 32'(io_ack),   32'd0);

      // I/O write, then a processor load of the same word
      io_req = 1'b1; io_wren = 1'b1; io_addr = 12'h020; io_wdata = 32'h5;
      tick();
      io_req = 1'b0;
      #1;
      check("wr_wren", 32'(mem_wren), 32'd1);
      check("wr_addr", 32'(mem_addr), 32'h020);
      tick();
      check("wr_ack",   32'(io_ack), 32'd1);
      check("wr_rdata", io_rdata,    32'hDEAD_BEEF);
      proc_en = 1'b1; proc_wren = 1'b0; proc_addr = 12'h020;
      #6;
      check("lw_after_wr", proc_q, 32'h5);
      tick();
      proc_en = 1'b0;
      tick();

      // starvation: processor holds the port for MAX_WAIT cycles, then is stalled once
      mem[12'h030] = 32'h1234_5678;
      proc_en = 1'b1; proc_wren = 1'b0; proc_addr = 12'h100;
      io_req = 1'b1; io_wren = 1'b0; io_addr = 12'h030;
      tick();
      io_req = 1'b0;
      owned = 0; found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (proc_stall) found = 1'b1;
         else begin
            owned++;
            tick();
         end
      end
      check("starve_forced", 32'(found),    32'd1);
      check("starve_owned",  32'(owned),    32'd8);
      check("starve_addr",   32'(mem_addr), 32'h030);
      tick();
      check("starve_ack",    32'(io_ack),      32'd1);
      check("starve_stalls", 32'(stall_count), 32'd1);
      check("starve_retry",  32'(proc_stall),  32'd0);
      check("starve_rdata",  io_rdata,         32'h1234_5678);
      proc_en = 1'b0;
      tick();

      // back-to-back requests with io_req held for 6 edges
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         io_req = 1'b1; io_wren = 1'($urandom_range(0, 1));
         io_addr = 12'($urandom_range(0, 15)); io_wdata = $urandom();
         tick();
         if (io_ack) acks++;
      end
      io_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (io_ack) acks++;
      end
      check("b2b_acks", 32'(acks), 32'd3);

      // asynchronous reset while a contended request is pending
      proc_en = 1'b1; proc_addr = 12'h0AB;
      io_req = 1'b1; io_wren = 1'b0; io_addr = 12'h040;
      tick();
      io_req = 1'b0;
      tick();
      check("pre_rst_busy", 32'(io_busy), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("arst_busy",  32'(io_busy),     32'd0);
      check("arst_ack",   32'(io_ack),      32'd0);
      check("arst_stall", 32'(stall_count), 32'd0);
      tick();
      reset = 1'b0; proc_en = 1'b0;
      acks = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (io_ack) acks++;
      end
      check("arst_no_ack",   32'(acks),     32'd0);
      check("arst_mem_addr", 32'(mem_addr), 32'h0AB);

      // stall counter saturation: continuously contended reads force >20 stalls
      proc_en = 1'b1; io_req = 1'b1; io_wren = 1'b0;
      for (int i = 0; i < 230; i++) begin
         io_addr = 12'($urandom_range(0, 15));
         proc_addr = 12'($urandom_range(0, 15));
         tick();
      end
      io_req = 1'b0; proc_en = 1'b0;
      tick();
      check("stall_sat", 32'(stall_count), 32'(SAT));

      // randomised traffic on a small address window to force collisions
      for (int i = 0; i < 1500; i++) begin
         proc_en    = ($urandom_range(0, 9) < 7);
         proc_wren  = 1'($urandom_range(0, 1));
         proc_addr  = 12'($urandom_range(0, 15));
         proc_wdata = $urandom();
         io_req     = ($urandom_range(0, 2) == 0);
         io_wren    = 1'($urandom_range(0, 1));
         io_addr    = 12'($urandom_range(0, 15));
         io_wdata   = $urandom();
         tick();
      end

      proc_en = 1'b0; io_req = 1'b0;
      repeat (4) tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
